// File: rtl/main_pkg.sv
// Shared constants and types for the blink controller and its UART.
package main_pkg;

  localparam logic [7:0] CHAR_OFF   = 8'h30;
  localparam logic [7:0] CHAR_ON    = 8'h31;
  localparam int         DATA_BITS  = 8;
  localparam logic       STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  function automatic logic [7:0] led_char(input logic on);
    return on ? CHAR_ON : CHAR_OFF;
  endfunction

endpackage

// File: rtl/main_uart.sv
// 8N1 UART transmitter/receiver pair; transmitter built only with MAIN_TX_REPORT_EN.
module main_uart
  import main_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  // sync_q[1] is the synchronised line, sync_q[2] its previous value
  logic [2:0]           sync_q;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_s;

  assign rx_s    = sync_q[1];
  assign rx_data = shift_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bits_d       = bits_q;
    shift_d      = shift_q;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q[2] && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // a start bit that is high again at mid-bit was a glitch
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bits_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bits_q == BIT_LAST) state_d = STOP;
          else                    bits_d  = bits_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (rx_s == STOP_LEVEL) rx_valid     = 1'b1;
          else                    rx_frame_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAIN_TX_REPORT_EN
  localparam logic [3:0] FRAME_LAST = 4'(DATA_BITS + 1);

  logic [DATA_BITS+1:0] frame_q, frame_d;
  logic [CW-1:0]        tcnt_q, tcnt_d;
  logic [3:0]           tbit_q, tbit_d;
  logic                 busy_q, busy_d;

  assign tx      = busy_q ? frame_q[0] : STOP_LEVEL;
  assign tx_busy = busy_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frame_q <= '0;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    frame_d = frame_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (tx_start) begin
        frame_d = {STOP_LEVEL, tx_data, ~STOP_LEVEL};
        tcnt_d  = '0;
        tbit_d  = '0;
        busy_d  = 1'b1;
      end
    end else if (tcnt_q == CNT_LAST) begin
      tcnt_d  = '0;
      frame_d = {STOP_LEVEL, frame_q[DATA_BITS+1:1]};
      if (tbit_q == FRAME_LAST) busy_d = 1'b0;
      else                      tbit_d = tbit_q + 1'b1;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end
`else
  logic tx_unused;
  assign tx_unused = ^{tx_start, tx_data};
  assign tx        = STOP_LEVEL;
  assign tx_busy   = 1'b0;
`endif

endmodule

// File: rtl/main.sv
// Blink controller: reset stretch, LED timer, UART pause/resume and trap latch.
// LED reports on tx are built only when MAIN_TX_REPORT_EN is defined.
module main
  import main_pkg::*;
#(
  parameter int RESET_BIT    = 3,
  parameter int TIMER_BITS   = 9,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic nreset,
  output logic ntrap,
  output logic led,
  output logic tx,
  input  logic rx
);

  logic [RESET_BIT:0]    rst_cnt_q, rst_cnt_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic                  led_q, led_d;
  logic                  pause_q, pause_d;
  logic                  trap_q, trap_d;
  logic                  run, advance, wrap;
  logic                  tx_start, tx_busy, rx_valid, rx_frame_err;
  logic [DATA_BITS-1:0]  tx_data, rx_data;

  assign run     = rst_cnt_q[RESET_BIT];
  assign advance = run & ~pause_q & ~trap_q;
  assign wrap    = advance & (&timer_q);

  assign ntrap    = run & ~trap_q;
  assign led      = led_q;
  assign tx_start = wrap & ~tx_busy;
  assign tx_data  = led_char(led_d);

  // pause/trap act from registered state, so a command landing on a wrap edge lets that toggle through
  always_comb begin
    rst_cnt_d = run ? rst_cnt_q : rst_cnt_q + 1'b1;
    timer_d   = advance ? timer_q + 1'b1 : timer_q;
    led_d     = led_q ^ wrap;
    pause_d   = pause_q;
    trap_d    = trap_q | (run & rx_frame_err);
    if (run && rx_valid) begin
      if (rx_data == CHAR_OFF)     pause_d = 1'b1;
      else if (rx_data == CHAR_ON) pause_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rst_cnt_q <= '0;
      timer_q   <= '0;
      led_q     <= 1'b0;
      pause_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      pause_q   <= pause_d;
      trap_q    <= trap_d;
    end
  end

  main_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk         (clk),
    .nreset      (nreset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx          (tx),
    .rx          (rx),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err)
  );

endmodule

// File: tb/tb_main.sv
// Randomised bench for main: reset stretch, blink period, tx reports, pause, trap, recovery.
`timescale 1ns/100ps
module tb_main;

  localparam int RB      = 3;
  localparam int TBITS   = 9;
  localparam int CPB     = 4;
  localparam int STRETCH = 1 << RB;
  localparam int PERIOD  = 1 << TBITS;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic rx = 1'b1;
  logic ntrap, led, tx;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  // observed LED toggles and decoded tx frames
  int         tq[$];
  logic       led_prev = 1'b0;
  logic [7:0] fb[$];
  int         fs[$];
  logic [1:0] fflag[$];
  logic [7:0] d_byte;
  logic       d_st, d_sp;
  int         d_s;

  // reference expectations
  int         et[$];
  logic       el[$];
`ifdef MAIN_TX_REPORT_EN
  logic [7:0] eb[$];
  int         es[$];
`endif

  main #(
    .RESET_BIT   (RB),
    .TIMER_BITS  (TBITS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .ntrap (ntrap),
    .led   (led),
    .tx    (tx),
    .rx    (rx)
  );

  always #1 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nreset && led !== led_prev) tq.push_back(cyc);
    led_prev <= led;
  end

  always begin
    @(negedge clk);
    if (nreset && tx === 1'b0) begin
      d_s = cyc;
      repeat (CPB / 2) @(negedge clk);
      d_st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        d_byte[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      d_sp = tx;
      fb.push_back(d_byte);
      fs.push_back(d_s);
      fflag.push_back({d_st, d_sp});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic predict(input int t, input logic lv);
    et.push_back(t);
    el.push_back(lv);
`ifdef MAIN_TX_REPORT_EN
    eb.push_back(lv ? 8'h31 : 8'h30);
    es.push_back(t);
`endif
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_tog(input int n);
    int b = 0;
    while (tq.size() < n && b < 4000) begin
      @(negedge clk);
      b++;
    end
    check("toggle_seen", (tq.size() >= n) ? 1 : 0, 1);
    if (tq.size() >= n) begin
      check("toggle_cycle", tq[n-1], et[n-1]);
      check("toggle_led", led, el[n-1]);
    end
  endtask

  task automatic wait_frame(input int k);
`ifdef MAIN_TX_REPORT_EN
    int b = 0;
    while (fb.size() <= k && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("frame_seen", (fb.size() > k) ? 1 : 0, 1);
    if (fb.size() > k) begin
      check("frame_byte", fb[k], eb[k]);
      check("frame_start", fs[k], es[k]);
      check("frame_start_stop", fflag[k], 2'b01);
    end
`else
    check("tx_no_frame", fb.size(), k - k);
    check("tx_idle", tx, 1'b1);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int f0);
    @(negedge clk);
    rx = 1'b0;
    f0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic stretch_check(output int rel);
    nreset = 1'b1;
    rel = cyc;
    for (int k = 1; k <= STRETCH; k++) begin
      @(negedge clk);
      check("stretch_ntrap", ntrap, (k == STRETCH) ? 1 : 0);
      check("stretch_led", led, 1'b0);
    end
  endtask

  initial begin
    int rel, t, p0, r0, f0, len, gap, b, d;
    logic [7:0] junk;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_led", led, 1'b0);
      check("rst_tx", tx, 1'b1);
      check("rst_ntrap", ntrap, 1'b0);
    end
    stretch_check(rel);

    t = rel + STRETCH + PERIOD;
    predict(t, 1'b1);
    wait_tog(1);
    wait_frame(0);
    t += PERIOD;
    predict(t, 1'b0);
    wait_tog(2);
    wait_frame(1);

    // bytes other than the two commands must not disturb the timer
    for (int n = 0; n < 2; n++) begin
      do junk = 8'($urandom_range(0, 255)); while (junk == 8'h30 || junk == 8'h31);
      send_frame(junk, 1'b1, f0);
    end
    t += PERIOD;
    predict(t, 1'b1);
    wait_tog(3);
    wait_frame(2);
    check("ignore_ntrap", ntrap, 1'b1);

    gap = $urandom_range(20, 150);
    wait_until(t + 40 + gap);
    send_frame(8'h30, 1'b1, p0);
    len = $urandom_range(2050, 2300);
    wait_until(p0 + 2045);
    check("pause_hold_tog", tq.size(), 3);
    check("pause_hold_led", led, 1'b1);
    wait_until(p0 + len);
    send_frame(8'h31, 1'b1, r0);
    t += PERIOD + (r0 - p0);
    predict(t, 1'b0);
    wait_tog(4);
    wait_frame(3);

    // trap frame timed so the error lands while the next report is on the wire
    t += PERIOD;
    predict(t, 1'b1);
    gap = $urandom_range(20, 38);
    wait_until(t - gap);
    send_frame(8'($urandom_range(0, 255)), 1'b0, f0);
    b = 0;
    while (ntrap && b < 100) begin
      @(negedge clk);
      b++;
    end
    d = cyc - f0;
    check("trap_fell", ntrap, 1'b0);
    check("trap_latency", (d >= 38 && d <= 44) ? 1 : 0, 1);
    wait_tog(5);
    wait_frame(4);
    wait_until(cyc + 1200);
    check("trap_frozen_tog", tq.size(), 5);
    check("trap_led", led, 1'b1);
    check("trap_ntrap", ntrap, 1'b0);
    check("trap_tx", tx, 1'b1);
`ifdef MAIN_TX_REPORT_EN
    check("trap_no_frame", fb.size(), 5);
`endif

    @(negedge clk);
    nreset = 1'b0;
    #0.2;
    check("arst_led", led, 1'b0);
    check("arst_tx", tx, 1'b1);
    check("arst_ntrap", ntrap, 1'b0);
    repeat (3) @(negedge clk);
    stretch_check(rel);
    t = rel + STRETCH + PERIOD;
    predict(t, 1'b1);
    wait_tog(6);
    wait_frame(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
